// File: rtl/tt_um_uart_byte_tx_pkg.sv
// rtl/tt_um_uart_byte_tx_pkg.sv - shared encodings and field positions for the UART byte transmitter
package tt_um_uart_byte_tx_pkg;

    // Frame phases; the code is exported on uio_out[7:6]
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_TAIL  = 2'b11
    } state_e;

    // uio_in fields
    localparam int UIO_IN_VALID    = 0;
    localparam int UIO_IN_PAR_EN   = 1;
    localparam int UIO_IN_TWO_STOP = 2;

    // uo_out fields
    localparam int UO_TXD  = 0;
    localparam int UO_BUSY = 1;
    localparam int UO_DONE = 2;

    // uio_out fields
    localparam int UIO_BUSY      = 4;
    localparam int UIO_DONE      = 5;
    localparam int UIO_STATE_LSB = 6;

    // Upper nibble of the bidirectional pins is always an output
    localparam logic [7:0] UIO_OE_MASK = 8'b1111_0000;

    // Number of bits sent in TAIL: optional parity, one stop, optional second stop
    function automatic logic [1:0] tail_len(input logic par_en, input logic two_stop);
        return 2'd1 + {1'b0, par_en} + {1'b0, two_stop};
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period timer producing a one-cycle pulse on the last cycle of each bit
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic bit_end
);

    localparam logic [11:0] LAST = 12'(CLKS_PER_BIT - 1);

    logic [11:0] cnt_q;
    logic [11:0] cnt_d;

    assign bit_end = (cnt_q == LAST);

    // Count cycles within a bit; restart on every bit boundary or when held clear
    always_comb begin
        cnt_d = cnt_q + 12'd1;
        if (clr || bit_end) begin
            cnt_d = 12'd0;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 12'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tt_um_uart_byte_tx.sv
// rtl/tt_um_uart_byte_tx.sv - serialises one byte per request onto a UART TX line
module tt_um_uart_byte_tx
    import tt_um_uart_byte_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_e     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic       par_en_q, par_en_d;
    logic       two_stop_q, two_stop_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [1:0] tail_idx_q, tail_idx_d;
    logic       txd_q, txd_d;
    logic       done_q, done_d;

    logic       bit_end;
    logic       busy;
    logic       valid;
    logic       unused_inputs;

    assign valid         = uio_in[UIO_IN_VALID];
    assign busy          = (state_q != ST_IDLE);
    assign unused_inputs = &{ena, uio_in[7:3]};

    // Baud timer is held at zero while idle so START always gets a full bit
    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state_q == ST_IDLE),
        .bit_end(bit_end)
    );

    // Next-state logic; txd_d is the line level for the upcoming cycle
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        par_d      = par_q;
        par_en_d   = par_en_q;
        two_stop_d = two_stop_q;
        bit_idx_d  = bit_idx_q;
        tail_idx_d = tail_idx_q;
        txd_d      = txd_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                if (valid) begin
                    shift_d    = ui_in;
                    par_en_d   = uio_in[UIO_IN_PAR_EN];
                    two_stop_d = uio_in[UIO_IN_TWO_STOP];
                    par_d      = 1'b0;
                    bit_idx_d  = 3'd0;
                    tail_idx_d = 2'd0;
                    state_d    = ST_START;
                    txd_d      = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                    txd_d     = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    // Parity accumulates the bit that just finished on the line
                    par_d = par_q ^ shift_q[0];
                    if (bit_idx_q == 3'd7) begin
                        state_d    = ST_TAIL;
                        tail_idx_d = 2'd0;
                        txd_d      = par_en_q ? (par_q ^ shift_q[0]) : 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        txd_d     = shift_q[1];
                    end
                end
            end
            ST_TAIL: begin
                if (bit_end) begin
                    txd_d = 1'b1;
                    if (tail_idx_q == tail_len(par_en_q, two_stop_q) - 2'd1) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        tail_idx_d = tail_idx_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    // State and datapath registers; txd leaves the chip straight from txd_q
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= 8'd0;
            par_q      <= 1'b0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            bit_idx_q  <= 3'd0;
            tail_idx_q <= 2'd0;
            txd_q      <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            par_en_q   <= par_en_d;
            two_stop_q <= two_stop_d;
            bit_idx_q  <= bit_idx_d;
            tail_idx_q <= tail_idx_d;
            txd_q      <= txd_d;
            done_q     <= done_d;
        end
    end

    // Status pin mapping
    always_comb begin
        uo_out                                  = 8'd0;
        uo_out[UO_TXD]                          = txd_q;
        uo_out[UO_BUSY]                         = busy;
        uo_out[UO_DONE]                         = done_q;
        uio_out                                 = 8'd0;
        uio_out[UIO_BUSY]                       = busy;
        uio_out[UIO_DONE]                       = done_q;
        uio_out[UIO_STATE_LSB+1:UIO_STATE_LSB]  = state_q;
        uio_oe                                  = UIO_OE_MASK;
    end

endmodule

// File: tb/tb_tt_um_uart_byte_tx.sv
// tb/tb_tt_um_uart_byte_tx.sv - self-checking bench for the UART byte transmitter
module tb_tt_um_uart_byte_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'd0;
    logic [7:0] uio_in = 8'd0;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int failures = 0;

    tt_um_uart_byte_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    // Reference: each accepted frame becomes a list of per-cycle (txd, phase code)
    typedef struct packed {
        logic       txd;
        logic [1:0] code;
    } cyc_t;

    cyc_t mq[$];
    logic m_done = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       two_stop;
        int         exp_len;
        logic       exp_par;
    } vec_t;

    vec_t vecs[6];
    logic frame_log[$];
    int   done_seen;

    task automatic push_bit(input logic b, input logic [1:0] code);
        cyc_t c;
        c.txd  = b;
        c.code = code;
        for (int k = 0; k < CPB; k++) mq.push_back(c);
    endtask

    task automatic build_frame(input logic [7:0] d, input logic pe, input logic ts);
        int ones;
        ones = 0;
        push_bit(1'b0, 2'b01);
        for (int i = 0; i < 8; i++) begin
            push_bit(d[i], 2'b10);
            if (d[i]) ones++;
        end
        if (pe) push_bit((ones % 2) == 1, 2'b11);
        push_bit(1'b1, 2'b11);
        if (ts) push_bit(1'b1, 2'b11);
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            mq.delete();
            m_done = 1'b0;
        end else if (mq.size() == 0) begin
            m_done = 1'b0;
            if (uio_in[0]) build_frame(ui_in, uio_in[1], uio_in[2]);
        end else begin
            void'(mq.pop_front());
            m_done = (mq.size() == 0);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model on the edge, compare all outputs on the falling edge
    task automatic step();
        logic       busy;
        logic [7:0] e_uo;
        logic [7:0] e_uio;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        busy  = (mq.size() != 0);
        e_uo  = {5'b0, m_done, busy, busy ? mq[0].txd : 1'b1};
        e_uio = {busy ? mq[0].code : 2'b00, m_done, busy, 4'b0};
        check8("uo_out", uo_out, e_uo);
        check8("uio_out", uio_out, e_uio);
        check8("uio_oe", uio_oe, 8'hF0);
        if (uo_out[1]) frame_log.push_back(uo_out[0]);
        if (uo_out[2]) done_seen++;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_seen == 0 && n < budget) begin
            step();
            n++;
        end
        check_int("done_within_budget", done_seen, 1);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 40, 1'b0};
        vecs[1] = '{8'h07, 1'b1, 1'b0, 44, 1'b1};
        vecs[2] = '{8'h03, 1'b1, 1'b0, 44, 1'b0};
        vecs[3] = '{8'h55, 1'b0, 1'b1, 44, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 48, 1'b0};
        vecs[5] = '{8'h80, 1'b1, 1'b0, 44, 1'b1};

        // Reset held with valid asserted: nothing may start
        rst_n  = 1'b0;
        uio_in = 8'h01;
        ui_in  = 8'hA5;
        for (int i = 0; i < 3; i++) step();
        check8("reset_uo", uo_out, 8'h01);
        uio_in = 8'h00;
        rst_n  = 1'b1;
        step();
        step();

        // Table-driven single frames
        for (int v = 0; v < 6; v++) begin
            frame_log.delete();
            done_seen = 0;
            ui_in  = vecs[v].data;
            uio_in = {5'b0, vecs[v].two_stop, vecs[v].par_en, 1'b1};
            step();
            check_int("accept_txd_low", int'(uo_out[0]), 0);
            uio_in = 8'h00;
            ui_in  = ~vecs[v].data;
            wait_done(80);
            check_int("frame_len", frame_log.size(), vecs[v].exp_len);
            if (vecs[v].par_en && frame_log.size() > 37)
                check_int("parity_bit", int'(frame_log[37]), int'(vecs[v].exp_par));
            step();
            step();
        end

        // Back-to-back 8N2 with valid held; ui_in changes mid-frame
        done_seen = 0;
        ui_in  = 8'h55;
        uio_in = 8'h05;
        for (int i = 0; i < 90; i++) begin
            if (i == 20) ui_in = 8'hFF;
            if (i == 50) uio_in = 8'h00;
            step();
        end
        check_int("b2b_done_count", done_seen, 2);
        for (int i = 0; i < 5; i++) step();

        // Valid pulses during DATA are ignored
        done_seen = 0;
        ui_in  = 8'h3C;
        uio_in = 8'h01;
        step();
        uio_in = 8'h00;
        for (int i = 0; i < 30; i++) begin
            uio_in = (i == 8 || i == 20) ? 8'h01 : 8'h00;
            step();
        end
        uio_in = 8'h00;
        for (int i = 0; i < 30; i++) step();
        check_int("ignore_done_count", done_seen, 1);

        // Reset at cycle 15 of a frame truncates it without done
        done_seen = 0;
        ui_in  = 8'hC3;
        uio_in = 8'h07;
        step();
        uio_in = 8'h00;
        for (int i = 0; i < 14; i++) step();
        rst_n = 1'b0;
        step();
        check8("mid_reset_uo", uo_out, 8'h01);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check_int("mid_reset_no_done", done_seen, 0);
        frame_log.delete();
        ui_in  = 8'h5A;
        uio_in = 8'h01;
        step();
        uio_in = 8'h00;
        wait_done(80);
        check_int("post_reset_len", frame_log.size(), 40);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            ui_in  = 8'($urandom);
            uio_in = {5'($urandom), 2'($urandom), ($urandom_range(0, 2) == 0)};
            rst_n  = ($urandom_range(0, 199) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
